// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator.
package serial_cmp_pkg;

    // Running relation between the two operands seen so far
    typedef enum logic [1:0] {
        REL_EQ = 2'd0,
        REL_LT = 2'd1,
        REL_GT = 2'd2
    } cmp_rel_t;

    // Compare sequencer states
    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } cmp_state_t;

endpackage

// File: rtl/serial_cmp_step.sv
// One bit-step of the serial compare: folds a bit pair into the running relation.
module serial_cmp_step
    import serial_cmp_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  cmp_rel_t rel,
    input  logic     a,
    input  logic     b,
    input  logic     is_sign_bit,
    input  logic     signed_mode,
    output cmp_rel_t rel_next
);

    logic invert;
    logic a_wins;

    // A differing sign bit in two's complement means the operand with the 1 is smaller
    always_comb begin
        invert   = is_sign_bit & signed_mode;
        a_wins   = a ^ invert;
        rel_next = rel;
        if (a != b) begin
            if (MSB_FIRST) begin
                // First difference from the top decides; later bits cannot override it
                if (rel == REL_EQ) rel_next = a_wins ? REL_GT : REL_LT;
            end else begin
                // Each more significant difference overrides what lower bits said
                rel_next = a_wins ? REL_GT : REL_LT;
            end
        end
    end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial magnitude comparator with start/busy/done handshake.
module serial_magnitude_comparator
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic signed_mode,
    input  logic a,
    input  logic b,
    output logic busy,
    output logic done,
    output logic L,
    output logic E,
    output logic G
);

    localparam int            CW       = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST     = CW'(WIDTH - 1);
    localparam logic [CW-1:0] SIGN_IDX = MSB_FIRST ? '0 : LAST;

    cmp_state_t    state;
    cmp_rel_t      rel;
    cmp_rel_t      rel_in;
    cmp_rel_t      rel_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] idx;
    logic          sm_q;
    logic          sm_cur;
    logic          is_sign;

    // In IDLE the step sees the start-cycle bit against a fresh EQ relation and live mode
    always_comb begin
        idx     = (state == S_IDLE) ? '0 : cnt;
        rel_in  = (state == S_IDLE) ? REL_EQ : rel;
        sm_cur  = (state == S_IDLE) ? signed_mode : sm_q;
        is_sign = (idx == SIGN_IDX);
    end

    serial_cmp_step #(
        .MSB_FIRST(MSB_FIRST)
    ) u_step (
        .rel        (rel_in),
        .a          (a),
        .b          (b),
        .is_sign_bit(is_sign),
        .signed_mode(sm_cur),
        .rel_next   (rel_next)
    );

    // Sequencer, bit counter, mode latch and registered result
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            rel   <= REL_EQ;
            cnt   <= '0;
            sm_q  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            L     <= 1'b0;
            E     <= 1'b0;
            G     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sm_q <= signed_mode;
                        rel  <= rel_next;
                        if (WIDTH == 1) begin
                            // Single-bit operands finish on the start edge itself
                            cnt  <= '0;
                            done <= 1'b1;
                            L    <= (rel_next == REL_LT);
                            E    <= (rel_next == REL_EQ);
                            G    <= (rel_next == REL_GT);
                        end else begin
                            cnt   <= CW'(1);
                            busy  <= 1'b1;
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    rel <= rel_next;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        L     <= (rel_next == REL_LT);
                        E     <= (rel_next == REL_EQ);
                        G     <= (rel_next == REL_GT);
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench: LSB-first/32, MSB-first/32 and 1-bit comparator instances.
module tb_serial_magnitude_comparator;

    localparam logic [2:0] RL = 3'b100;  // {L,E,G}
    localparam logic [2:0] RE = 3'b010;
    localparam logic [2:0] RG = 3'b001;

    typedef struct {
        int         d;
        logic [2:0] leg;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] start, sm, a, b;
    logic [2:0] busy, done, L, E, G;
    int         cyc = 0;
    int         total = 0;
    int         passed = 0;
    exp_t       sb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_magnitude_comparator #(.WIDTH(32), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .start(start[0]), .signed_mode(sm[0]), .a(a[0]), .b(b[0]),
        .busy(busy[0]), .done(done[0]), .L(L[0]), .E(E[0]), .G(G[0]));
    serial_magnitude_comparator #(.WIDTH(32), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .start(start[1]), .signed_mode(sm[1]), .a(a[1]), .b(b[1]),
        .busy(busy[1]), .done(done[1]), .L(L[1]), .E(E[1]), .G(G[1]));
    serial_magnitude_comparator #(.WIDTH(1), .MSB_FIRST(1'b0)) u_w1 (
        .clk(clk), .rst(rst), .start(start[2]), .signed_mode(sm[2]), .a(a[2]), .b(b[2]),
        .busy(busy[2]), .done(done[2]), .L(L[2]), .E(E[2]), .G(G[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Drive one full stream starting at the current negedge; expectation is queued first
    task automatic cmp(input int d, input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic s, input logic [2:0] leg, input int repulse);
        int t0;
        t0 = cyc + 1;
        sb.push_back('{d, leg, t0 + w - 1});
        for (int k = 0; k < w; k++) begin
            int bi;
            bi       = (d == 1) ? (w - 1 - k) : k;
            start[d] = (k == 0) || (k == repulse);
            sm[d]    = s;
            a[d]     = av[bi];
            b[d]     = bv[bi];
            @(negedge clk);
            if (k < w - 1) chk("busy_mid", {31'd0, busy[d]}, 32'd1);
        end
        start[d] = 1'b0;
    endtask

    // Monitor: every done pulse must match the oldest expectation for that instance
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (done[d]) begin
                int found;
                found = -1;
                for (int i = 0; i < sb.size(); i++)
                    if (found < 0 && sb[i].d == d) found = i;
                if (found < 0) begin
                    total++;
                    $display("FAIL unexpected_done: inst %0d pulsed done at cycle %0d with none expected", d, cyc);
                end else begin
                    chk("result_leg", {29'd0, L[d], E[d], G[d]}, {29'd0, sb[found].leg});
                    chk("done_cycle", cyc, sb[found].cyc);
                    chk("busy_at_done", {31'd0, busy[d]}, 32'd0);
                    sb.delete(found);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = '0; sm = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_busy", {31'd0, busy[d]}, 32'd0);
            chk("reset_done", {31'd0, done[d]}, 32'd0);
            chk("reset_leg", {29'd0, L[d], E[d], G[d]}, 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // LSB-first, 32-bit
        cmp(0, 32, 32'hFFFF_FFFF, 32'd123, 1'b0, RG, -1); @(negedge clk);
        cmp(0, 32, 32'hFFFF_FFFF, 32'd123, 1'b1, RL, -1); @(negedge clk);
        cmp(0, 32, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, RL, -1); @(negedge clk);

        // MSB-first, 32-bit
        cmp(1, 32, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, RG, -1); @(negedge clk);
        cmp(1, 32, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1, RL, -1); @(negedge clk);
        cmp(1, 32, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b0, RE, -1); @(negedge clk);
        cmp(1, 32, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 1'b1, RE, -1); @(negedge clk);
        cmp(1, 32, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, RL, -1); @(negedge clk);

        // Reset 10 cycles into a compare: no done, outputs cleared
        for (int k = 0; k < 10; k++) begin
            start[0] = (k == 0); sm[0] = 1'b0; a[0] = 1'b1; b[0] = 1'b0;
            @(negedge clk);
        end
        start[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", {31'd0, busy[0]}, 32'd0);
        chk("midrst_done", {31'd0, done[0]}, 32'd0);
        chk("midrst_leg", {29'd0, L[0], E[0], G[0]}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        cmp(0, 32, 32'd5, 32'd5, 1'b0, RE, -1); @(negedge clk);

        // start re-pulsed mid-compare is ignored
        cmp(0, 32, 32'hFFFF_FFFF, 32'd123, 1'b0, RG, 5); @(negedge clk);

        // Back-to-back: second start in the done cycle
        cmp(0, 32, 32'd3, 32'd7, 1'b0, RL, -1);
        cmp(0, 32, 32'd7, 32'd3, 1'b1, RG, -1); @(negedge clk);

        // WIDTH=1 instance
        cmp(2, 1, 32'd1, 32'd0, 1'b0, RG, -1); @(negedge clk);
        cmp(2, 1, 32'd1, 32'd0, 1'b1, RL, -1); @(negedge clk);
        cmp(2, 1, 32'd1, 32'd1, 1'b1, RE, -1); @(negedge clk);

        // start coincident with rst: rst wins
        rst = 1'b1; start[0] = 1'b1; a[0] = 1'b1; b[0] = 1'b0;
        @(negedge clk);
        chk("rst_start_busy", {31'd0, busy[0]}, 32'd0);
        rst = 1'b0; start[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_stays_low", {31'd0, busy[0]}, 32'd0);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
